// File: rtl/fft_trim_pkg.sv
// Shared types and helpers for the FFT frame trimmer.
// Holds the trim state enum, default sizing constants and the
// range helpers used to decide which bins of a frame are forwarded.
package fft_trim_pkg;

  typedef enum logic [1:0] {
    SKIP  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } trim_state_e;

  localparam int DEFAULT_FRAME_LEN = 256;
  localparam int DEFAULT_DATA_W    = 32;

  // Exclusive end of the forwarded range, clipped to the frame length.
  // Evaluated in 32 bits so lo+cnt can never wrap.
  function automatic int unsigned calcHiExcl(input int unsigned lo,
                                             input int unsigned cnt,
                                             input int unsigned frameLen);
    int unsigned sum;
    sum = lo + cnt;
    if (sum > frameLen) begin
      calcHiExcl = frameLen;
    end else begin
      calcHiExcl = sum;
    end
  endfunction

  // Which region a bin index falls into for a given [lo, hiExcl) range.
  function automatic trim_state_e binState(input int unsigned k,
                                           input int unsigned lo,
                                           input int unsigned hiExcl);
    if (k < lo) begin
      binState = SKIP;
    end else if (k < hiExcl) begin
      binState = PASS;
    end else begin
      binState = DRAIN;
    end
  endfunction

endpackage

// File: rtl/trim_skid_buf.sv
// Two-entry valid/ready register slice.
// The head entry drives the outputs directly from registers; the second
// entry absorbs one beat while the consumer stalls, so the producer can
// run at one beat per cycle and only sees backpressure when both are full.
module trim_skid_buf
  import fft_trim_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] inData_i,
  input  logic             inValid_i,
  output logic             inReady_o,
  output logic [WIDTH-1:0] outData_o,
  output logic             outValid_o,
  input  logic             outReady_i
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             skidValid_q, skidValid_d;
  logic             push;

  assign inReady_o  = ~skidValid_q;
  assign outData_o  = outData_q;
  assign outValid_o = outValid_q;
  assign push       = inValid_i & ~skidValid_q;

  // Next-state: refill the head from the skid entry first to keep order,
  // otherwise from the input; park the input in the skid entry on a stall.
  always_comb begin
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    skidData_d  = skidData_q;
    skidValid_d = skidValid_q;
    if (~outValid_q | outReady_i) begin
      if (skidValid_q) begin
        outData_d   = skidData_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
      end else begin
        outValid_d = push;
        if (push) begin
          outData_d = inData_i;
        end
      end
    end else if (push) begin
      skidData_d  = inData_i;
      skidValid_d = 1'b1;
    end
  end

  // Register both entries; reset empties the slice and zeroes the data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      skidData_q  <= '0;
      skidValid_q <= 1'b0;
    end else begin
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      skidData_q  <= skidData_d;
      skidValid_q <= skidValid_d;
    end
  end

endmodule

// File: rtl/fft_frame_trim.sv
// Frame-aware bin selector between the FFT power core and the MFCC
// filterbank. Counts the bins of each frame, forwards the contiguous range
// [cfg_bin_lo, cfg_bin_lo+cfg_bin_cnt) clipped to the frame, and drains every
// other bin at full rate so the FFT buffer always empties.
// A frame ends on bin FRAME_LEN-1 or on s_last, whichever comes first; any
// disagreement between the two sets the sticky err_sync flag.
// Optional build macro FFT_TRIM_STATS_EN adds frame_cnt and err_cnt outputs.
module fft_frame_trim
  import fft_trim_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [CNT_W-1:0]  cfg_bin_lo,
  input  logic [CNT_W:0]    cfg_bin_cnt,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              frame_done,
  output logic              err_sync
`ifdef FFT_TRIM_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam int HI_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] binCnt_q, binCnt_d;
  trim_state_e      state_q, state_d, curState;
  logic [CNT_W-1:0] lo_q, lo_d, curLo;
  logic [HI_W-1:0]  hi_q, hi_d, curHi, liveHi;
  logic             frameDone_q, frameDone_d;
  logic             errSync_q, errSync_d;

  logic             firstBin, isFinalBin, accept, push, pushLast;
  logic             frameEnd, syncErr, bufReady, bufValid;
  logic [DATA_W:0]  bufOut;

  // Range the live configuration would select if it were latched now.
  assign liveHi = HI_W'(calcHiExcl(32'(cfg_bin_lo), 32'(cfg_bin_cnt),
                                   32'(FRAME_LEN)));

  // Bin 0 always uses the live configuration, because the config is
  // captured on that very beat and may have changed since the last frame
  // ended; later bins use the latched copy and the registered state.
  always_comb begin
    firstBin   = (binCnt_q == '0);
    isFinalBin = (binCnt_q == LAST_BIN);
    curLo      = firstBin ? cfg_bin_lo : lo_q;
    curHi      = firstBin ? liveHi : hi_q;
    curState   = firstBin ? binState(32'd0, 32'(cfg_bin_lo), 32'(liveHi))
                          : state_q;
    s_ready    = ~rst & ((curState == PASS) ? bufReady : 1'b1);
    accept     = s_valid & s_ready;
    push       = accept & (curState == PASS);
    frameEnd   = accept & (isFinalBin | s_last);
    syncErr    = frameEnd & (s_last != isFinalBin);
    pushLast   = ({1'b0, binCnt_q} == (curHi - HI_W'(1))) | frameEnd;
  end

  // Per-beat next state: latch config on bin 0, advance or wrap the bin
  // counter, and classify the next bin so the state tracks the next k.
  always_comb begin
    binCnt_d    = binCnt_q;
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    frameDone_d = 1'b0;
    errSync_d   = errSync_q | syncErr;
    if (accept) begin
      if (firstBin) begin
        lo_d = cfg_bin_lo;
        hi_d = liveHi;
      end
      if (frameEnd) begin
        binCnt_d    = '0;
        frameDone_d = 1'b1;
        state_d     = binState(32'd0, 32'(cfg_bin_lo), 32'(liveHi));
      end else begin
        binCnt_d = binCnt_q + CNT_W'(1);
        state_d  = binState(32'(binCnt_q) + 32'd1, 32'(curLo), 32'(curHi));
      end
    end
  end

  // Frame tracking registers; reset aborts any frame in progress.
  always_ff @(posedge hclk) begin
    if (rst) begin
      binCnt_q    <= '0;
      state_q     <= SKIP;
      lo_q        <= '0;
      hi_q        <= '0;
      frameDone_q <= 1'b0;
      errSync_q   <= 1'b0;
    end else begin
      binCnt_q    <= binCnt_d;
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      frameDone_q <= frameDone_d;
      errSync_q   <= errSync_d;
    end
  end

  trim_skid_buf #(
    .WIDTH(DATA_W + 1)
  ) u_skid (
    .clk_i      (hclk),
    .rst_i      (rst),
    .inData_i   ({pushLast, s_data}),
    .inValid_i  (push),
    .inReady_o  (bufReady),
    .outData_o  (bufOut),
    .outValid_o (bufValid),
    .outReady_i (m_ready)
  );

  assign m_data     = bufOut[DATA_W-1:0];
  assign m_valid    = bufValid;
  assign m_last     = bufOut[DATA_W] & bufValid;
  assign frame_done = frameDone_q;
  assign err_sync   = errSync_q;

`ifdef FFT_TRIM_STATS_EN
  logic [15:0] frameCnt_q;
  logic [7:0]  errCnt_q;

  // Frame counter wraps naturally; error counter saturates at its maximum.
  always_ff @(posedge hclk) begin
    if (rst) begin
      frameCnt_q <= '0;
      errCnt_q   <= '0;
    end else begin
      if (frameDone_q) begin
        frameCnt_q <= frameCnt_q + 16'd1;
      end
      if (syncErr && (errCnt_q != 8'hFF)) begin
        errCnt_q <= errCnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt = frameCnt_q;
  assign err_cnt   = errCnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/fft_frame_trim.md
Name: fft_frame_trim

Overview:
- Frame-aware bin selector between the FFT power core and the downstream MFCC filterbank.
- Counts bins of each FRAME_LEN-point power frame and forwards only the contiguous range [bin_lo, bin_lo+bin_cnt).
- Drains all other bins at full rate so the FFT buffer always empties; flags the last forwarded bin and the end of every frame.
- Generalises fixed 256-point, zero-offset trimming to a parametrised length, start offset, registered output and frame-sync checking.

Parameters:
DATA_W, 32, bin data width
FRAME_LEN, 256, bins per frame (power of two, 4..4096)
CNT_W, $clog2(FRAME_LEN), bin counter / config width

Ports:
hclk  in  1  clock
rst  in  1  synchronous, active-high reset
s_data  in  DATA_W  bin data from FFT core
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
s_last  in  1  FFT marks bin FRAME_LEN-1
cfg_bin_lo  in  CNT_W  first bin to forward
cfg_bin_cnt  in  CNT_W+1  number of bins to forward (0..FRAME_LEN)
m_data  out  DATA_W  forwarded bin
m_valid  out  1  output valid
m_ready  in  1  downstream ready
m_last  out  1  with the last forwarded bin of a frame
frame_done  out  1  one-cycle pulse after the final input bin of a frame is accepted
err_sync  out  1  sticky: s_last / bin-count mismatch; cleared only by rst

Behaviour:
- Reset (rst high at a hclk edge):
  - Clears bin counter, state, skid buffer and config latch.
  - m_valid=0, m_last=0, m_data=0, frame_done=0, err_sync=0.
  - s_ready is forced to 0 while rst is high.
  - Reset mid-frame discards buffered bins; no m_last or frame_done is produced for the aborted frame.
- Config latch:
  - cfg_bin_lo and cfg_bin_cnt are sampled on acceptance of bin 0 of each frame and held until that frame ends.
  - Changes mid-frame take effect at the next frame.
- Effective range: lo=cfg_bin_lo; hi_excl=min(lo+cnt, FRAME_LEN). The sum is computed at CNT_W+2 bits, so there is no wrap.
- FSM, evaluated per accepted beat with bin index k:
  - SKIP (k<lo): beat dropped, s_ready=1.
  - PASS (lo<=k<hi_excl): beat pushed into the skid buffer; s_ready = buffer not full.
  - DRAIN (k>=hi_excl): beat dropped, s_ready=1.
  - The state is a function of the next k; the transition happens on the accepting edge.
  - After bin FRAME_LEN-1 the next state is SKIP if new lo>0, else PASS (cnt>0) or DRAIN (cnt=0).
- m_last is attached to the beat with k=hi_excl-1. If cnt=0, nothing is forwarded and no m_last is produced.
- Output skid buffer:
  - 2 entries; m_data/m_valid/m_last are driven from registers.
  - Latency: accepted PASS beat -> m_valid 1 cycle later when the buffer is empty.
  - Sustains 1 beat/cycle with m_ready held high.
  - m_valid, m_data and m_last stay stable while m_valid & ~m_ready.
- Frame end / sync:
  - A frame ends on acceptance of k=FRAME_LEN-1 or of a beat with s_last=1, whichever comes first.
  - frame_done pulses the cycle after; the counter returns to 0.
  - If s_last=1 at k!=FRAME_LEN-1, or s_last=0 at k=FRAME_LEN-1, set err_sync and still end the frame (resynchronise).
  - If the early end cuts PASS short, force m_last on that beat when it was forwarded; otherwise no m_last.
- Simultaneous events:
  - Push and pop on the same edge with the buffer full: the pop frees an entry, but s_ready was already 0 that cycle, so there is no push.
  - frame_done and the first beat of the next frame may coincide.

Optional Feature:
- FFT_TRIM_STATS_EN defined:
  - Adds output frame_cnt[15:0], incremented on every frame_done and wrapping at 0xFFFF->0.
  - Adds output err_cnt[7:0], incremented on each sync error and saturating at 0xFF.
  - Both reset to 0.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package fft_trim_pkg:
  - State enum {SKIP, PASS, DRAIN}.
  - Default FRAME_LEN and DATA_W constants.
  - Function computing hi_excl with clipping.
- One natural sub-module: trim_skid_buf, a 2-entry valid/ready register slice (DATA_W+1 wide for data+last), reused on other stream outputs.

Test Plan:
- lo=0, cnt=128, FRAME_LEN=256, m_ready=1, continuous input -> bins 0..127 forwarded, m_last on bin 127, 128 bins drained, frame_done 1 cycle after bin 255, err_sync=0.
- lo=10, cnt=20 -> m_data equals input bins 10..29 in order, m_last on bin 29; s_ready stays 1 throughout SKIP/DRAIN.
- lo=250, cnt=40 -> clipped to bins 250..255 (6 beats), m_last on bin 255.
- cnt=0 -> no m_valid for the whole frame, frame_done still pulses once; cfg changed to lo=0, cnt=4 mid-frame -> applies only to the next frame.
- lo=0, cnt=256, m_ready toggled 1/0 at random -> all 256 bins delivered in order with no loss or duplication, outputs stable while stalled.
- s_last asserted at k=100 -> frame ends, err_sync=1 sticky, next beat treated as bin 0; rst asserted mid-PASS -> m_valid=0 next cycle, err_sync=0.
